rmon_ctr_ram: RTL
=================

# rmon_ctr_ram

Parametrised RMON statistics counter store. It replaces the plain 32x64 counter dual-port RAM with a self-contained read-modify-write engine. The RMON update logic posts (address, delta) increments, and the block accumulates them in place. The CPU reads counters through a second handshaked channel, with optional clear-on-read and saturating or wrapping arithmetic. After reset, the block zeroes every entry itself before accepting any traffic.

## Interface
Parameters:
- DATA_W, 32, counter width in bits.
- ADDR_W, 6, counter address width; the block holds 2^ADDR_W counters.
- DELTA_W, 16, width of the increment; must be ≤ DATA_W.
- SATURATE, 0, 1 = counters stick at all-ones; 0 = counters wrap modulo 2^DATA_W.
- CLR_ON_RD, 0, 1 = a CPU read writes zero to the counter in the same slot.

Ports:
- Clk  in  1  single clock.
- Reset  in  1  synchronous, active-low reset.
- Init_busy  out  1  high during the post-reset zeroing sweep.
- Upd_valid  in  1  update request.
- Upd_ready  out  1  update accepted when Upd_valid && Upd_ready.
- Upd_addr  in  ADDR_W  counter to increment.
- Upd_delta  in  DELTA_W  increment, zero-extended.
- Cpu_rd_req  in  1  CPU read request; held until accepted.
- Cpu_rd_rdy  out  1  CPU read accepted when Cpu_rd_req && Cpu_rd_rdy.
- Cpu_addr  in  ADDR_W  counter to read.
- Cpu_rd_ack  out  1  one-cycle pulse; Cpu_dout is valid in that cycle.
- Cpu_dout  out  DATA_W  counter value before any clear; held until the next ack.

## Operation
- Reset values (Reset=0 sampled at an edge): Init_busy=1, Upd_ready=0, Cpu_rd_rdy=0, Cpu_rd_ack=0, Cpu_dout=0. All pipeline valids are cleared.
- Init sweep:
  - Starts on the first edge with Reset=1.
  - Writes zero to address 0 … 2^ADDR_W−1, one entry per cycle.
  - Init_busy drops in the cycle after the last write.
  - Both ready outputs stay 0 throughout the sweep.
- FSM states: INIT → RUN. Reset returns to INIT from any state. There is no other transition.
- RUN, slot arbitration (one operation per cycle):
  - A CPU read has priority over an update. Cpu_rd_rdy = Cpu_rd_req && RUN.
  - Upd_ready = RUN && !Cpu_rd_req.
  - The update side never blocks the CPU. The CPU can starve updates only while it holds Cpu_rd_req.
- Pipeline: S0 accepts the operation and issues the RAM read. S1 receives the RAM data, applies forwarding, computes the result, and writes the RAM.
- Update arithmetic: sum = old + zero-extended delta, computed DATA_W+1 bits wide.
  - SATURATE=1: on a carry-out, write all-ones.
  - SATURATE=0: write the low DATA_W bits.
  - A delta of 0 is a legal update and rewrites the same value.
- CPU operation in S1:
  - Captures old → Cpu_dout.
  - CLR_ON_RD=1: writes 0 to the counter.
  - CLR_ON_RD=0: performs no write.
- Hazard forwarding: if S1 writes address A while S0 reads A, S0's RAM data is stale. S1 of that next operation uses the forwarded registered write value instead. A back-to-back stream to the same address therefore accumulates exactly.
- Reset mid-operation: in-flight S0/S1 operations are discarded with no write, no ack, and no partial update. The sweep then restarts from address 0.

## Timing
- Update accepted at edge N: RAM holds the new value after edge N+1. A read accepted at edge N+1 observes it.
- CPU read accepted at edge N: Cpu_rd_ack=1 and Cpu_dout are valid during cycle N+2 (registered output). When CLR_ON_RD=1, the clear is committed at edge N+1.
- Throughput: 1 operation per cycle, with no bubbles, including same-address back-to-back operations.
- Init sweep: 2^ADDR_W cycles; Upd_ready can first be 1 at cycle 2^ADDR_W+1 after reset release.

## Structure
- Shared package `rmon_pkg`: op-type enum {OP_UPD, OP_RD}, FSM state enum {ST_INIT, ST_RUN}, and a saturating-add function parametrised by width.
- One sub-module, `rmon_sdpram`: simple dual-port RAM, depth 2^ADDR_W, width DATA_W.
  - One write port and one read port, both on Clk.
  - 1-cycle registered read, read-old-on-collision.
  - Forwarding logic stays in rmon_ctr_ram.

## Test plan
- Reset release: Init_busy high for exactly 64 cycles (ADDR_W=6). Afterwards, a CPU read of every address returns 0.
- Five back-to-back updates to address 5 with delta 1,2,3,4,5: a CPU read of address 5 returns 15, proving the forwarding path.
- SATURATE=1, DATA_W=8: counter at 250, delta 10 → read returns 255. With SATURATE=0 the same stimulus returns 4.
- CLR_ON_RD=1: counter at 7; read address 7 returns 7; a second read returns 0. An update of +3 issued in the cycle after the first read is accepted leaves the counter at 3.
- Simultaneous Cpu_rd_req and Upd_valid for 3 cycles: Upd_ready=0 throughout; the update is accepted in the first cycle without a CPU request, and no update is lost.
- Reset asserted while updates are in S0/S1: no ack follows; after the new sweep, every counter reads 0.

Source files
------------

// File: rtl/rmon_pkg.sv
// Shared types and arithmetic for the RMON counter store.
package rmon_pkg;

  typedef enum logic {
    OP_UPD = 1'b0,
    OP_RD  = 1'b1
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MAX_W = 64;

  // Add two w-bit values held in MAX_W containers; clamp to all-ones on carry when sat is set.
  function automatic logic [MAX_W-1:0] sat_add(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int               w,
    input logic             sat
  );
    logic [MAX_W:0] sum;
    logic [MAX_W:0] mask;
    logic [MAX_W:0] carry;
    mask  = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
    sum   = {1'b0, a} + {1'b0, b};
    carry = sum >> w;
    if (sat && carry[0]) begin
      sat_add = mask[MAX_W-1:0];
    end else begin
      sat_add = sum[MAX_W-1:0] & mask[MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rmon_sdpram.sv
// Simple dual-port counter RAM: one write port, one registered read port, read-old on collision.
module rmon_sdpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rmon_ctr_ram.sv
// RMON statistics counter store: self-zeroing after reset, in-place read-modify-write
// of posted increments, and a priority CPU read channel with optional clear-on-read.
module rmon_ctr_ram
  import rmon_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 6,
  parameter int DELTA_W   = 16,
  parameter int SATURATE  = 0,
  parameter int CLR_ON_RD = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               Init_busy,
  input  logic               Upd_valid,
  output logic               Upd_ready,
  input  logic [ADDR_W-1:0]  Upd_addr,
  input  logic [DELTA_W-1:0] Upd_delta,
  input  logic               Cpu_rd_req,
  output logic               Cpu_rd_rdy,
  input  logic [ADDR_W-1:0]  Cpu_addr,
  output logic               Cpu_rd_ack,
  output logic [DATA_W-1:0]  Cpu_dout
);

  state_e             state;
  logic [ADDR_W-1:0]  init_addr;
  logic               run;

  logic               rd_fire;
  logic               upd_fire;
  logic               s0_valid;
  op_e                s0_op;
  logic [ADDR_W-1:0]  s0_addr;

  logic               s1_valid;
  op_e                s1_op;
  logic [ADDR_W-1:0]  s1_addr;
  logic [DELTA_W-1:0] s1_delta;
  logic               s1_fwd;
  logic [DATA_W-1:0]  s1_fwd_data;
  logic [DATA_W-1:0]  s1_old;
  logic [DATA_W-1:0]  s1_sum;
  logic [DATA_W-1:0]  s1_wdata;
  logic               s1_we;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  assign run        = (state == ST_RUN);
  assign Init_busy  = (state == ST_INIT);
  assign Cpu_rd_rdy = Cpu_rd_req && run;
  assign Upd_ready  = run && !Cpu_rd_req;

  assign rd_fire  = Cpu_rd_req && Cpu_rd_rdy;
  assign upd_fire = Upd_valid && Upd_ready;

  always_comb begin
    s0_valid = rd_fire || upd_fire;
    s0_op    = rd_fire ? OP_RD : OP_UPD;
    s0_addr  = rd_fire ? Cpu_addr : Upd_addr;
  end

  // The RAM read for S0 cannot see the write S1 commits on the same edge; s1_fwd covers that.
  always_comb begin
    s1_old   = s1_fwd ? s1_fwd_data : ram_rdata;
    s1_sum   = DATA_W'(sat_add(MAX_W'(s1_old), MAX_W'(s1_delta), DATA_W, SATURATE != 0));
    s1_we    = s1_valid && ((s1_op == OP_UPD) || (CLR_ON_RD != 0));
    s1_wdata = (s1_op == OP_UPD) ? s1_sum : '0;
  end

  // A write on an edge where Reset is low belongs to a discarded operation.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr;
    ram_wdata = s1_wdata;
    if (Reset) begin
      if (state == ST_INIT) begin
        ram_we    = 1'b1;
        ram_waddr = init_addr;
        ram_wdata = '0;
      end else begin
        ram_we = s1_we;
      end
    end
  end

  rmon_sdpram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(s0_addr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= ST_INIT;
      init_addr   <= '0;
      s1_valid    <= 1'b0;
      s1_op       <= OP_UPD;
      s1_addr     <= '0;
      s1_delta    <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      Cpu_rd_ack  <= 1'b0;
      Cpu_dout    <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_addr <= init_addr + ADDR_W'(1);
        if (init_addr == '1) begin
          state <= ST_RUN;
        end
      end
      s1_valid    <= s0_valid;
      s1_op       <= s0_op;
      s1_addr     <= s0_addr;
      s1_delta    <= Upd_delta;
      s1_fwd      <= s1_we && (s1_addr == s0_addr);
      s1_fwd_data <= s1_wdata;
      Cpu_rd_ack  <= s1_valid && (s1_op == OP_RD);
      if (s1_valid && (s1_op == OP_RD)) begin
        Cpu_dout <= s1_old;
      end
    end
  end

endmodule
